btb_predictor: RTL and testbench

//  Fetch-side next-PC predictor: direct-mapped branch target buffer with 2-bit saturating counters.
//  IF looks up the fetch PC each cycle and gets a predicted next_pc.
//  EX sends back each resolved control-flow outcome (taken/target/mispredict), which trains the table.

---
 rtl/btb_predictor.sv | 169 ++++++++++++++++
 tb/tb_btb_predictor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
//   Fetch-side next-PC predictor. It is a direct-mapped branch target buffer
//   with a 2-bit saturating direction counter per entry.
//   IF looks up if_pc every cycle and gets a combinational prediction.
//   EX returns resolved control-flow outcomes, and these train the table on
//   the next posedge.
//   Saturating performance counters track the resolved branches/jumps and the
//   mispredicts.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   if_pc           fetch PC to predict for
//   pred_taken      predicted redirect for if_pc
//   pred_next_pc    predicted next PC (target on redirect, else if_pc+4)
//   upd_valid       EX resolved a valid instruction this cycle
//   upd_pc          PC of the resolved instruction
//   upd_is_br       resolved instruction is a conditional branch
//   upd_is_jump     resolved instruction is jal/jalr (wins over upd_is_br)
//   upd_taken       actual outcome (taken branch or jump)
//   upd_target      actual next PC when taken
//   upd_mispredict  EX saw a wrong next-PC prediction
//   stat_cf_count   saturating count of resolved branch/jump updates
//   stat_mp_count   saturating count of mispredicts
// -----------------------------------------------------------------------------
module btb_predictor #(
  parameter int         IDX_BITS  = 6,
  parameter logic [1:0] CTR_ALLOC = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_br,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] stat_cf_count,
  output logic [31:0] stat_mp_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             is_jump;
    logic [1:0]       ctr;
  } entry_t;

  logic [ENTRIES-1:0] valid_q;
  entry_t             entry_q [ENTRIES];

  // PC byte-offset bits never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Fetch-side lookup. It sees pre-update state because there is no bypass.
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]    if_tag;
  entry_t              if_entry;
  logic                if_hit;

  assign if_idx   = if_pc[IDX_BITS+1:2];
  assign if_tag   = if_pc[31:IDX_BITS+2];
  assign if_entry = entry_q[if_idx];
  assign if_hit   = valid_q[if_idx] && (if_entry.tag == if_tag);

  always_comb begin
    pred_taken   = if_hit && (if_entry.is_jump || if_entry.ctr[1]);
    pred_next_pc = pred_taken ? if_entry.target : if_pc + 32'd4;
  end

  // ---------------------------------------------------------------------------
  // Update decode
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  entry_t              upd_entry;
  logic                upd_hit;

  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_tag   = upd_pc[31:IDX_BITS+2];
  assign upd_entry = entry_q[upd_idx];
  assign upd_hit   = valid_q[upd_idx] && (upd_entry.tag == upd_tag);

  logic   wr_en;
  logic   set_valid;
  logic   clr_valid;
  entry_t wr_data;

  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    wr_en     = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    wr_data   = upd_entry;
    if (upd_valid) begin
      if (upd_is_jump) begin
        // A jump always (re)installs an entry, even when the branch flag is also set.
        wr_en     = 1'b1;
        set_valid = 1'b1;
        wr_data   = '{tag: upd_tag, target: upd_target, is_jump: 1'b1, ctr: 2'b11};
      end else if (upd_is_br) begin
        if (upd_hit) begin
          wr_en           = 1'b1;
          wr_data.is_jump = 1'b0;
          if (upd_taken) begin
            wr_data.target = upd_target;
            if (upd_entry.ctr != 2'b11) wr_data.ctr = upd_entry.ctr + 2'd1;
          end else begin
            if (upd_entry.ctr != 2'b00) wr_data.ctr = upd_entry.ctr - 2'd1;
          end
        end else if (upd_taken) begin
          wr_en     = 1'b1;
          set_valid = 1'b1;
          wr_data   = '{tag: upd_tag, target: upd_target, is_jump: 1'b0, ctr: CTR_ALLOC};
        end
      end else if (upd_hit) begin
        // A non-branch hit means a stale or aliased entry would redirect it.
        clr_valid = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Reads within
  // the same edge then see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[upd_idx] <= 1'b1;
    end else if (clr_valid) begin
      valid_q[upd_idx] <= 1'b0;
    end
  end

  // NOTE: the entry payload array has no reset. The valid bits alone decide
  // whether an entry is live, so this array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      entry_q[upd_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cf_count <= '0;
      stat_mp_count <= '0;
    end else if (upd_valid) begin
      if ((upd_is_br || upd_is_jump) && (stat_cf_count != 32'hFFFF_FFFF))
        stat_cf_count <= stat_cf_count + 32'd1;
      if (upd_mispredict && (stat_mp_count != 32'hFFFF_FFFF))
        stat_mp_count <= stat_mp_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// -----------------------------------------------------------------------------
// tb_btb_predictor
//   Self-checking bench for btb_predictor. Directed scenarios are followed by
//   randomized traffic. The traffic is compared against an index-addressed
//   reference table that applies the training rules in plain arithmetic.
// -----------------------------------------------------------------------------
module tb_btb_predictor;

  localparam int IDX_BITS = 6;
  localparam int ENTRIES  = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_br;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] stat_cf_count;
  logic [31:0] stat_mp_count;

  btb_predictor #(.IDX_BITS(IDX_BITS), .CTR_ALLOC(2'b10)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_next_pc   (pred_next_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_br      (upd_is_br),
    .upd_is_jump    (upd_is_jump),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .stat_cf_count  (stat_cf_count),
    .stat_mp_count  (stat_mp_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid  [ENTRIES];
  logic [31:0] m_pc_tag [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  bit          m_jump   [ENTRIES];
  int          m_ctr    [ENTRIES];
  longint      m_cf, m_mp;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_BITS + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_pc_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_jump[idx_of(pc)] || m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_next(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_cf = 0;
    m_mp = 0;
  endtask

  task automatic model_update();
    int i;
    bit hit;
    i   = idx_of(upd_pc);
    hit = m_hit(upd_pc);
    if (upd_is_jump) begin
      m_valid[i] = 1; m_pc_tag[i] = tag_of(upd_pc); m_target[i] = upd_target;
      m_jump[i] = 1; m_ctr[i] = 3;
    end else if (upd_is_br) begin
      if (hit) begin
        m_jump[i] = 0;
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1; m_pc_tag[i] = tag_of(upd_pc); m_target[i] = upd_target;
        m_jump[i] = 0; m_ctr[i] = 2;
      end
    end else if (hit) begin
      m_valid[i] = 0;
    end
    if (upd_is_br || upd_is_jump) m_cf = (m_cf >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cf + 1;
    if (upd_mispredict)           m_mp = (m_mp >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_mp + 1;
  endtask

  // ---------------- stimulus helpers ----------------
  // One clock: the model trains on the edge, then the bench returns 1ns later.
  task automatic cycle();
    @(posedge clk);
    if (!rst && upd_valid) model_update();
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input bit br, input bit jmp, input bit tkn,
                         input logic [31:0] tgt, input bit mp);
    upd_valid = 1'b1; upd_pc = pc; upd_is_br = br; upd_is_jump = jmp;
    upd_taken = tkn; upd_target = tgt; upd_mispredict = mp;
  endtask

  task automatic clr_upd();
    upd_valid = 1'b0; upd_is_br = 1'b0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input bit br, input bit jmp, input bit tkn,
                           input logic [31:0] tgt, input bit mp);
    set_upd(pc, br, jmp, tkn, tgt, mp);
    cycle();
    clr_upd();
  endtask

  task automatic expect_pred(input string tag, input logic [31:0] pc, input logic [31:0] exp_next);
    if_pc = pc;
    #1;
    check(tag, pred_next_pc, exp_next);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    if_pc = 32'h100; upd_pc = '0; upd_target = '0;
    clr_upd();
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    #1;

    // Reset state
    #1;
    check("reset_taken", {31'd0, pred_taken}, 32'd0);
    check("reset_next", pred_next_pc, 32'h104);
    check("reset_cf", stat_cf_count, 32'd0);
    check("reset_mp", stat_mp_count, 32'd0);

    // Branch training
    do_update(32'h100, 1, 0, 1, 32'h80, 1);
    expect_pred("br_alloc_next", 32'h100, 32'h80);
    check("br_alloc_taken", {31'd0, pred_taken}, 32'd1);
    do_update(32'h100, 1, 0, 0, 32'h0, 0);
    expect_pred("br_ctr01", 32'h100, 32'h104);
    do_update(32'h100, 1, 0, 0, 32'h0, 0);
    do_update(32'h100, 1, 0, 0, 32'h0, 0);
    do_update(32'h100, 1, 0, 1, 32'h88, 0);
    expect_pred("br_ctr_floor", 32'h100, 32'h104);
    do_update(32'h100, 1, 0, 1, 32'h8C, 0);
    expect_pred("br_retrain", 32'h100, 32'h8C);

    // Jump, aliasing, invalidation
    do_update(32'h200, 0, 1, 1, 32'h400, 0);
    expect_pred("jump_hit", 32'h200, 32'h400);
    do_update(32'h200 + (32'h1 << (IDX_BITS + 2)), 0, 1, 1, 32'h600, 0);
    expect_pred("alias_miss", 32'h200, 32'h204);
    expect_pred("alias_new", 32'h300, 32'h600);
    do_update(32'h200, 1, 1, 0, 32'h440, 0);
    expect_pred("jump_over_br", 32'h200, 32'h440);
    do_update(32'h200, 0, 0, 0, 32'h0, 0);
    expect_pred("nonbr_clear", 32'h200, 32'h204);

    // Same-cycle lookup and update
    do_reset();
    set_upd(32'h300, 1, 0, 1, 32'h500, 0);
    expect_pred("same_cycle_pre", 32'h300, 32'h304);
    cycle();
    clr_upd();
    expect_pred("same_cycle_post", 32'h300, 32'h500);

    // Perf counters: 10 br/jump updates, 3 of them mispredicted
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_update(32'h1000 + 32'(i * 4), (i % 3) != 0, (i % 3) == 0, 1,
                32'h2000 + 32'(i * 16), (i == 1) || (i == 4) || (i == 7));
      if (i == 5) cycle();
    end
    #1;
    check("cf_ten", stat_cf_count, 32'd10);
    check("mp_three", stat_mp_count, 32'd3);
    do_update(32'h1100, 0, 0, 0, 32'h0, 1);
    check("mp_nonbr", stat_mp_count, 32'd4);
    check("cf_nonbr", stat_cf_count, 32'd10);

    // Reset asserted mid-run while an update is presented
    set_upd(32'h1000, 1, 0, 1, 32'h3000, 1);
    rst = 1'b1;
    model_reset();
    expect_pred("rst_async_miss", 32'h1004, 32'h1008);
    check("rst_async_cf", stat_cf_count, 32'd0);
    check("rst_async_mp", stat_mp_count, 32'd0);
    cycle();
    rst = 1'b0;
    clr_upd();
    expect_pred("rst_no_write", 32'h1000, 32'h1004);
    check("rst_cf_held", stat_cf_count, 32'd0);

    // Saturation: preload both counters at their ceiling
    force dut.stat_cf_count = 32'hFFFF_FFFF;
    force dut.stat_mp_count = 32'hFFFF_FFFF;
    do_update(32'h1200, 1, 0, 1, 32'h40, 1);
    release dut.stat_cf_count;
    release dut.stat_mp_count;
    m_cf = 64'hFFFF_FFFF;
    m_mp = 64'hFFFF_FFFF;
    do_update(32'h1204, 0, 1, 1, 32'h44, 1);
    do_update(32'h1208, 1, 0, 0, 32'h48, 1);
    #1;
    check("cf_saturate", stat_cf_count, 32'hFFFF_FFFF);
    check("mp_saturate", stat_mp_count, 32'hFFFF_FFFF);

    // Wrap of the sequential next PC
    do_reset();
    expect_pred("wrap_next", 32'hFFFF_FFFC, 32'h0000_0000);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      logic [31:0] fpc;
      int          kind;
      pc   = (32'($urandom_range(0, 3)) << (IDX_BITS + 2)) | (32'($urandom_range(0, 7)) << 2);
      kind = int'($urandom_range(0, 15));
      set_upd(pc, kind < 8 || kind == 15, (kind >= 8 && kind < 12) || kind == 15,
              1'($urandom), {$urandom} & 32'hFFFF_FFFC, 1'($urandom));
      upd_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0, 1, 2: fpc = pc;
        3:       fpc = 32'hFFFF_FFFC;
        default: fpc = (32'($urandom_range(0, 3)) << (IDX_BITS + 2)) | (32'($urandom_range(0, 7)) << 2);
      endcase
      if_pc = fpc;
      #1;
      check("rnd_taken", {31'd0, pred_taken}, {31'd0, m_pred_taken(fpc)});
      check("rnd_next", pred_next_pc, m_pred_next(fpc));
      check("rnd_cf", stat_cf_count, m_cf[31:0]);
      check("rnd_mp", stat_mp_count, m_mp[31:0]);
      if (n == 300) begin
        clr_upd();
        do_reset();
      end else begin
        cycle();
      end
    end
    clr_upd();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
